// File: rtl/switch_node_array.sv
// switch_node_array
//   Clocked resolver for WIDTH independent NMOS-style nodes. Each node may
//   carry a passive pull-up, N_UP switch-to-vcc devices and N_DOWN
//   switch-to-vss devices. Down devices are ratioed stronger than up devices,
//   so a fight resolves to 0. An undriven node keeps its charge for
//   HOLD_CYCLES cycles and then decays to DECAY_VALUE.
//
// Ports
//   clk          in   1               rising-edge clock
//   rst_n        in   1               synchronous active-low reset
//   up_gate      in   WIDTH*N_UP      gate of up device k of node i at i*N_UP+k
//   down_gate    in   WIDTH*N_DOWN    gate of down device k of node i at i*N_DOWN+k
//   y            out  WIDTH           registered node values
//   driven       out  WIDTH           node was strongly driven or pulled up
//   floating     out  WIDTH           node undriven and still holding charge
//   decayed      out  WIDTH           node undriven past HOLD_CYCLES
//   conflict     out  WIDTH           strong up and strong down both on
//   any_conflict out  1               OR of conflict, registered alongside it
module switch_node_array #(
    parameter int               WIDTH       = 8,
    parameter int               N_UP        = 2,
    parameter int               N_DOWN      = 2,
    parameter logic [WIDTH-1:0] PULLUP      = {WIDTH{1'b1}},
    parameter int               HOLD_CYCLES = 4,
    parameter logic             DECAY_VALUE = 1'b0,
    parameter logic [WIDTH-1:0] RESET_VALUE = {WIDTH{1'b0}}
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [WIDTH*N_UP-1:0]    up_gate,
    input  logic [WIDTH*N_DOWN-1:0]  down_gate,
    output logic [WIDTH-1:0]         y,
    output logic [WIDTH-1:0]         driven,
    output logic [WIDTH-1:0]         floating,
    output logic [WIDTH-1:0]         decayed,
    output logic [WIDTH-1:0]         conflict,
    output logic                     any_conflict
);

    // A zero hold time still needs a one-bit counter to exist.
    localparam int CW = (HOLD_CYCLES > 0) ? $clog2(HOLD_CYCLES + 1) : 1;
    localparam logic [CW-1:0] HOLD_LIMIT = CW'(HOLD_CYCLES);

    logic [WIDTH-1:0] y_reg,        y_next;
    logic [WIDTH-1:0] driven_reg,   driven_next;
    logic [WIDTH-1:0] floating_reg, floating_next;
    logic [WIDTH-1:0] decayed_reg,  decayed_next;
    logic [WIDTH-1:0] conflict_reg, conflict_next;
    logic             any_conflict_reg;

    genvar gi;
    generate
        for (gi = 0; gi < WIDTH; gi++) begin : g_node
            logic          sd, su, wu;
            logic [CW-1:0] count_reg, count_next;
            logic          y_n, drv_n, flt_n, dec_n, con_n;

            assign sd = |down_gate[gi*N_DOWN +: N_DOWN];
            assign su = |up_gate[gi*N_UP +: N_UP];
            assign wu = PULLUP[gi];

            always_comb begin
                count_next = count_reg;
                y_n        = y_reg[gi];
                drv_n      = 1'b0;
                flt_n      = 1'b0;
                dec_n      = 1'b0;
                con_n      = 1'b0;
                if (sd || su || wu) begin
                    // Any down device wins; otherwise strong up or pull-up gives 1.
                    drv_n      = 1'b1;
                    y_n        = ~sd;
                    con_n      = sd & su;
                    count_next = '0;
                end else if (count_reg < HOLD_LIMIT) begin
                    // Charge retained: y keeps its previous value.
                    flt_n      = 1'b1;
                    count_next = count_reg + 1'b1;
                end else begin
                    // Charge gone; counter stays saturated at the limit.
                    dec_n = 1'b1;
                    y_n   = DECAY_VALUE;
                end
            end

            always_ff @(posedge clk) begin
                if (!rst_n) begin
                    count_reg <= '0;
                end else begin
                    count_reg <= count_next;
                end
            end

            assign y_next[gi]        = y_n;
            assign driven_next[gi]   = drv_n;
            assign floating_next[gi] = flt_n;
            assign decayed_next[gi]  = dec_n;
            assign conflict_next[gi] = con_n;
        end
    endgenerate

    // During reset a pulled-up node reports no flag at all; a node without
    // a pull-up reports floating since it will hold RESET_VALUE as charge.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            y_reg            <= RESET_VALUE;
            driven_reg       <= '0;
            floating_reg     <= ~PULLUP;
            decayed_reg      <= '0;
            conflict_reg     <= '0;
            any_conflict_reg <= 1'b0;
        end else begin
            y_reg            <= y_next;
            driven_reg       <= driven_next;
            floating_reg     <= floating_next;
            decayed_reg      <= decayed_next;
            conflict_reg     <= conflict_next;
            any_conflict_reg <= |conflict_next;
        end
    end

    assign y            = y_reg;
    assign driven       = driven_reg;
    assign floating     = floating_reg;
    assign decayed      = decayed_reg;
    assign conflict     = conflict_reg;
    assign any_conflict = any_conflict_reg;

endmodule

// File: tb/tb_switch_node_array.sv
// Table-driven bench for switch_node_array with WIDTH=2, PULLUP=01,
// HOLD_CYCLES=3, DECAY_VALUE=0. Each vector gives the inputs applied before a
// rising edge and the outputs expected just after that edge.
module tb_switch_node_array;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [3:0] up_gate;
    logic [3:0] down_gate;
    logic [1:0] y, driven, floating, decayed, conflict;
    logic       any_conflict;

    int total = 0;
    int bad   = 0;

    switch_node_array #(
        .WIDTH(2), .N_UP(2), .N_DOWN(2), .PULLUP(2'b01),
        .HOLD_CYCLES(3), .DECAY_VALUE(1'b0), .RESET_VALUE(2'b00)
    ) dut (
        .clk(clk), .rst_n(rst_n), .up_gate(up_gate), .down_gate(down_gate),
        .y(y), .driven(driven), .floating(floating), .decayed(decayed),
        .conflict(conflict), .any_conflict(any_conflict)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic       rst_n;
        logic [3:0] up;
        logic [3:0] down;
        logic [1:0] y;
        logic [1:0] drv;
        logic [1:0] flt;
        logic [1:0] dec;
        logic [1:0] con;
        logic       any;
    } vec_t;

    function automatic vec_t mk(logic r, logic [3:0] u, logic [3:0] d,
                                logic [1:0] ey, logic [1:0] ed, logic [1:0] ef,
                                logic [1:0] ek, logic [1:0] ec, logic ea);
        vec_t v;
        v.rst_n = r; v.up = u; v.down = d;
        v.y = ey; v.drv = ed; v.flt = ef; v.dec = ek; v.con = ec; v.any = ea;
        return v;
    endfunction

    task automatic cmp2(string tag, string what, logic [1:0] got, logic [1:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s %s: got %b want %b", tag, what, got, want);
        end
    endtask

    task automatic run_vec(string tag, vec_t v);
        rst_n     = v.rst_n;
        up_gate   = v.up;
        down_gate = v.down;
        @(posedge clk);
        #1;
        cmp2(tag, "y",            y,                   v.y);
        cmp2(tag, "driven",       driven,              v.drv);
        cmp2(tag, "floating",     floating,            v.flt);
        cmp2(tag, "decayed",      decayed,             v.dec);
        cmp2(tag, "conflict",     conflict,            v.con);
        cmp2(tag, "any_conflict", {1'b0, any_conflict}, {1'b0, v.any});
        $display("%s rst_n=%b up=%b down=%b -> y=%b drv=%b flt=%b dec=%b con=%b any=%b",
                 tag, v.rst_n, v.up, v.down, y, driven, floating, decayed, conflict, any_conflict);
    endtask

    vec_t tbl[12];

    initial begin
        rst_n     = 1'b0;
        up_gate   = 4'h0;
        down_gate = 4'h0;
        #1;

        //           rst  up      down     y      drv    flt    dec    con    any
        tbl[0]  = mk(0, 4'b1111, 4'b1010, 2'b00, 2'b00, 2'b10, 2'b00, 2'b00, 0); // reset, gates ignored
        tbl[1]  = mk(0, 4'b0101, 4'b0011, 2'b00, 2'b00, 2'b10, 2'b00, 2'b00, 0);
        tbl[2]  = mk(1, 4'b0000, 4'b0000, 2'b01, 2'b01, 2'b10, 2'b00, 2'b00, 0); // pull-up node0, node1 holds 0 (cnt 1)
        tbl[3]  = mk(1, 4'b0000, 4'b0001, 2'b00, 2'b01, 2'b10, 2'b00, 2'b00, 0); // down beats pull-up (cnt 2)
        tbl[4]  = mk(1, 4'b0000, 4'b0000, 2'b01, 2'b01, 2'b10, 2'b00, 2'b00, 0); // pull-up returns (cnt 3)
        tbl[5]  = mk(1, 4'b0000, 4'b0000, 2'b01, 2'b01, 2'b00, 2'b10, 2'b00, 0); // node1 decays
        tbl[6]  = mk(1, 4'b1000, 4'b0100, 2'b01, 2'b11, 2'b00, 2'b00, 2'b10, 1); // fight on node1
        tbl[7]  = mk(1, 4'b1000, 4'b0000, 2'b11, 2'b11, 2'b00, 2'b00, 2'b00, 0); // fight cleared, up wins
        tbl[8]  = mk(1, 4'b0000, 4'b0000, 2'b11, 2'b01, 2'b10, 2'b00, 2'b00, 0); // hold 1
        tbl[9]  = mk(1, 4'b0000, 4'b0000, 2'b11, 2'b01, 2'b10, 2'b00, 2'b00, 0); // hold 2
        tbl[10] = mk(1, 4'b0000, 4'b0000, 2'b11, 2'b01, 2'b10, 2'b00, 2'b00, 0); // hold 3
        tbl[11] = mk(1, 4'b0000, 4'b0000, 2'b01, 2'b01, 2'b00, 2'b10, 2'b00, 0); // 4th undriven: decay

        for (int i = 0; i < 12; i++) begin
            run_vec($sformatf("vec%0d", i), tbl[i]);
        end

        // Decayed state must stay put: counter saturates, no wrap.
        for (int i = 0; i < 10; i++) begin
            run_vec($sformatf("stable%0d", i),
                    mk(1, 4'b0000, 4'b0000, 2'b01, 2'b01, 2'b00, 2'b10, 2'b00, 0));
        end

        // Re-drive after decay with node1 up device 0, then a full hold again.
        run_vec("redrive", mk(1, 4'b0100, 4'b0000, 2'b11, 2'b11, 2'b00, 2'b00, 2'b00, 0));
        for (int i = 0; i < 3; i++) begin
            run_vec($sformatf("rehold%0d", i),
                    mk(1, 4'b0000, 4'b0000, 2'b11, 2'b01, 2'b10, 2'b00, 2'b00, 0));
        end
        run_vec("redecay", mk(1, 4'b0000, 4'b0000, 2'b01, 2'b01, 2'b00, 2'b10, 2'b00, 0));

        // Reset while node1 is floating at count 2.
        run_vec("mh_drive", mk(1, 4'b0100, 4'b0000, 2'b11, 2'b11, 2'b00, 2'b00, 2'b00, 0));
        run_vec("mh_hold0", mk(1, 4'b0000, 4'b0000, 2'b11, 2'b01, 2'b10, 2'b00, 2'b00, 0));
        run_vec("mh_hold1", mk(1, 4'b0000, 4'b0000, 2'b11, 2'b01, 2'b10, 2'b00, 2'b00, 0));
        run_vec("mh_reset", mk(0, 4'b0000, 4'b0000, 2'b00, 2'b00, 2'b10, 2'b00, 2'b00, 0));
        for (int i = 0; i < 3; i++) begin
            run_vec($sformatf("mh_post%0d", i),
                    mk(1, 4'b0000, 4'b0000, 2'b01, 2'b01, 2'b10, 2'b00, 2'b00, 0));
        end
        run_vec("mh_decay", mk(1, 4'b0000, 4'b0000, 2'b01, 2'b01, 2'b00, 2'b10, 2'b00, 0));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
